// File: rtl/rat_intr_pkg.sv
// Shared definitions for the RAT MCU interrupt controller.
// Holds the request FSM encoding, the default port-map addresses and the
// lowest-index-wins priority helper.
package rat_intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } intr_state_t;

  localparam int MAX_SRC = 8;

  localparam logic [7:0] MASK_PORT_DEF = 8'h40;
  localparam logic [7:0] ACK_PORT_DEF  = 8'h41;
  localparam logic [7:0] STAT_PORT_DEF = 8'h42;
  localparam logic [7:0] ID_PORT_DEF   = 8'h43;

  // Index of the lowest set bit; zero when nothing is set (callers gate on |v).
  function automatic logic [2:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Purpose: bring one asynchronous interrupt line into CLK and flag its rising edge.
// Latency: edge first sampled at edge k yields a one-cycle rise pulse after edge k+1.
// Backpressure: none; a pulse is produced regardless of downstream state.
module intr_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // Two metastability flops plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Purpose: synchronize, latch, mask and prioritize interrupt sources into the RAT INTR line.
// Latency: source edge at k -> pend after k+2 -> INTR after k+4; ack at a -> INTR low after a+1.
// Backpressure: INTR is held until the ISR acks the active index; other events queue in pend.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] MASK_PORT = MASK_PORT_DEF,
  parameter logic [7:0] ACK_PORT  = ACK_PORT_DEF,
  parameter logic [7:0] STAT_PORT = STAT_PORT_DEF,
  parameter logic [7:0] ID_PORT   = ID_PORT_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] SRC,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic [7:0]         IN_DATA,
  output logic               INTR
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] ack_clr;
  logic [2:0]         act_id_q;
  logic [2:0]         win_id;
  logic               intr_q;
  logic               mask_wr;
  logic               ack_vld;
  logic               ack_act;
  intr_state_t        state_q;
  intr_state_t        state_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    intr_sync_edge u_sync (
      .clk  (CLK),
      .rst  (RST),
      .src  (SRC[g]),
      .rise (rise[g])
    );
  end

  // Port decode; ack bytes naming a nonexistent source are dropped entirely.
  assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT);
  assign ack_vld = IO_STRB && (PORT_ID == ACK_PORT) && (OUT_PORT < 8'(NUM_SRC));
  assign ack_act = ack_vld && (OUT_PORT[2:0] == act_id_q);

  // One-hot clear vector for the acknowledged source.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_vld && (OUT_PORT[2:0] == 3'(i))) ack_clr[i] = 1'b1;
    end
  end

  // Pending bits: a fresh edge outranks a same-cycle ack so no event is lost.
  always_ff @(posedge CLK) begin
    if (RST) pend_q <= '0;
    else     pend_q <= (pend_q & ~ack_clr) | rise;
  end

  // Enable mask, all sources enabled out of reset.
  always_ff @(posedge CLK) begin
    if (RST)          mask_q <= '1;
    else if (mask_wr) mask_q <= OUT_PORT[NUM_SRC-1:0];
  end

  assign req    = pend_q & mask_q;
  assign win_id = lowest_set(MAX_SRC'(req));

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: only the active index's ack ends a request; GAP forces a low cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req)   state_d = REQ;
      REQ:     if (ack_act) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Active index is frozen from IDLE->REQ until the next IDLE.
  always_ff @(posedge CLK) begin
    if (RST)                              act_id_q <= '0;
    else if ((state_q == IDLE) && (|req)) act_id_q <= win_id;
  end

  // INTR is a registered copy of "in REQ", one cycle behind the state.
  always_ff @(posedge CLK) begin
    if (RST) intr_q <= 1'b0;
    else     intr_q <= (state_q == REQ);
  end

  assign INTR = intr_q;

  // Combinational read mux for the IN instruction.
  always_comb begin
    IN_DATA = 8'h00;
    if (PORT_ID == STAT_PORT)    IN_DATA = 8'(pend_q);
    else if (PORT_ID == ID_PORT) IN_DATA = {5'b0, act_id_q};
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: directed scenarios for each feature plus a randomized
// run checked against a queue-style service-order model.
module tb_rat_intr_ctrl;

  localparam int         NSRC   = 4;
  localparam logic [7:0] P_MASK = 8'h40;
  localparam logic [7:0] P_ACK  = 8'h41;
  localparam logic [7:0] P_STAT = 8'h42;
  localparam logic [7:0] P_ID   = 8'h43;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [NSRC-1:0] SRC = '0;
  logic [7:0]      PORT_ID = 8'h00;
  logic [7:0]      OUT_PORT = 8'h00;
  logic            IO_STRB = 1'b0;
  logic [7:0]      IN_DATA;
  logic            INTR;

  int n_tests = 0;
  int n_fail  = 0;

  rat_intr_ctrl #(
    .NUM_SRC   (NSRC),
    .MASK_PORT (P_MASK),
    .ACK_PORT  (P_ACK),
    .STAT_PORT (P_STAT),
    .ID_PORT   (P_ID)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SRC      (SRC),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .IN_DATA  (IN_DATA),
    .INTR     (INTR)
  );

  always #5 CLK = ~CLK;

  // Advance n clock edges; we always sit 1 time unit after the last edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One OUT instruction: strobe is sampled on the next edge.
  task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
    PORT_ID  = port;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    step();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
  endtask

  task automatic rd(input logic [7:0] port, output logic [7:0] d);
    PORT_ID = port;
    #1;
    d = IN_DATA;
    PORT_ID = 8'h00;
  endtask

  task automatic wait_intr(input int max_cyc);
    int c = 0;
    while (INTR !== 1'b1 && c < max_cyc) begin
      step();
      c++;
    end
  endtask

  function automatic int lowest(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [7:0] d;
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", INTR); end
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_stat: got %h want 00", d); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_id: got %h want 00", d); end
    SRC = 4'b0001;
    step(4);
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL reset_mask_k3: got %b want 0", INTR); end
    step();
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL reset_mask_k4: got %b want 1", INTR); end
    SRC = '0;
    io_wr(P_ACK, 8'h00);
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", INTR); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int bad = 0;
    SRC = 4'b0100;
    step(2);
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL single_stat_k1: got %h want 00", d); end
    step();
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h04) begin n_fail++; $display("FAIL single_stat_k2: got %h want 04", d); end
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL single_intr_k3: got %b want 0", INTR); end
    step();
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL single_intr_k4: got %b want 1", INTR); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL single_id: got %h want 02", d); end
    repeat (5) begin step(); if (INTR !== 1'b1) bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL single_hold: got %0d low cycles want 0", bad); end
    SRC = '0;
    io_wr(P_ACK, 8'h02);
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL single_stat_ack: got %h want 00", d); end
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL single_gap: got %b want 0", INTR); end
    bad = 0;
    repeat (8) begin step(); if (INTR !== 1'b0) bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL single_no_second: got %0d high cycles want 0", bad); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    int bad = 0;
    SRC = 4'b1010;
    step(5);
    SRC = '0;
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL prio_intr1: got %b want 1", INTR); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL prio_id1: got %h want 01", d); end
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h0A) begin n_fail++; $display("FAIL prio_stat1: got %h want 0a", d); end
    io_wr(P_ACK, 8'h01);
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL prio_gap_a1: got %b want 0", INTR); end
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL prio_gap_a2: got %b want 0", INTR); end
    step();
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL prio_intr2_a3: got %b want 1", INTR); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL prio_id2: got %h want 03", d); end
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h08) begin n_fail++; $display("FAIL prio_stat2: got %h want 08", d); end
    io_wr(P_ACK, 8'h03);
    repeat (8) begin step(); if (INTR !== 1'b0) bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL prio_quiet: got %0d high cycles want 0", bad); end
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL prio_stat_end: got %h want 00", d); end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    int bad = 0;
    io_wr(P_MASK, 8'hFE);
    SRC = 4'b0001;
    step(2);
    SRC = '0;
    repeat (6) begin step(); if (INTR !== 1'b0) bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mask_blocked: got %0d high cycles want 0", bad); end
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL mask_stat: got %h want 01", d); end
    io_wr(P_MASK, 8'hFF);
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL mask_unmask_s1: got %b want 0", INTR); end
    step();
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL mask_unmask_s2: got %b want 1", INTR); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL mask_id: got %h want 00", d); end
    io_wr(P_ACK, 8'h00);
    step(2);
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL mask_ack: got %b want 0", INTR); end
  endtask

  task automatic test_boundaries();
    logic [7:0] d;
    SRC = 4'b1010;
    step(5);
    SRC = '0;
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL bnd_intr: got %b want 1", INTR); end
    io_wr(P_ACK, 8'h03);
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL bnd_other_stat: got %h want 02", d); end
    step(2);
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL bnd_other_intr: got %b want 1", INTR); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL bnd_other_id: got %h want 01", d); end
    io_wr(P_ACK, 8'h07);
    io_wr(P_ACK, 8'h04);
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL bnd_oob_stat: got %h want 02", d); end
    step(2);
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL bnd_oob_intr: got %b want 1", INTR); end
    // New SRC[1] edge lands on pend in the same cycle as its ack.
    SRC = 4'b0010;
    step(2);
    io_wr(P_ACK, 8'h01);
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL bnd_setwins_stat: got %h want 02", d); end
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL bnd_setwins_gap: got %b want 0", INTR); end
    step(2);
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL bnd_setwins_reassert: got %b want 1", INTR); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL bnd_setwins_id: got %h want 01", d); end
    SRC = '0;
    io_wr(P_ACK, 8'h01);
    step(6);
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL bnd_end_intr: got %b want 0", INTR); end
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL bnd_end_stat: got %h want 00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    SRC = 4'b0100;
    step(5);
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b want 1", INTR); end
    RST = 1'b1;
    SRC = '0;
    step();
    RST = 1'b0;
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL rmid_intr: got %b want 0", INTR); end
    rd(P_STAT, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rmid_stat: got %h want 00", d); end
    rd(P_ID, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rmid_id: got %h want 00", d); end
    step(3);
    SRC = 4'b0001;
    step(5);
    n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL rmid_after: got %b want 1", INTR); end
    SRC = '0;
    io_wr(P_ACK, 8'h00);
    step();
    n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL rmid_ack: got %b want 0", INTR); end
  endtask

  // Random source sets and masks: enabled sources must be serviced in ascending
  // index order, masked ones must stay visible in status but never interrupt.
  task automatic test_random(input int iters);
    logic [7:0]      d;
    logic [NSRC-1:0] m, s, pend;
    int              exp, j, start, idx, bad;
    for (int it = 0; it < iters; it++) begin
      m = NSRC'($urandom_range(0, 15));
      s = NSRC'($urandom_range(1, 15));
      io_wr(P_MASK, {4'b0, m});
      rd(P_STAT, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rand_pre_stat it%0d: got %h want 00", it, d); end
      SRC = s;
      step(2);
      SRC = '0;
      pend = s;
      for (int guard = 0; guard < NSRC && (pend & m) != 0; guard++) begin
        wait_intr(12);
        n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL rand_intr it%0d: got %b want 1", it, INTR); end
        exp = lowest(pend & m);
        rd(P_ID, d);
        n_tests++; if (d !== 8'(exp)) begin n_fail++; $display("FAIL rand_id it%0d: got %h want %h", it, d, 8'(exp)); end
        rd(P_STAT, d);
        n_tests++; if (d !== {4'b0, pend}) begin n_fail++; $display("FAIL rand_stat it%0d: got %h want %h", it, d, {4'b0, pend}); end
        if ($urandom_range(0, 2) == 0) begin
          j = -1;
          start = $urandom_range(0, NSRC - 1);
          for (int i = 0; i < NSRC; i++) begin
            idx = (start + i) % NSRC;
            if (pend[idx] && idx != exp && j < 0) j = idx;
          end
          if (j >= 0) begin
            io_wr(P_ACK, 8'(j));
            pend[j] = 1'b0;
            step();
            n_tests++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL rand_other_ack it%0d: got %b want 1", it, INTR); end
          end
        end
        if ($urandom_range(0, 3) == 0) io_wr(P_ACK, 8'($urandom_range(NSRC, 7)));
        io_wr(P_ACK, 8'(exp));
        pend[exp] = 1'b0;
        step();
        n_tests++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL rand_gap it%0d: got %b want 0", it, INTR); end
      end
      bad = 0;
      repeat (6) begin step(); if (INTR !== 1'b0) bad++; end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_quiet it%0d: got %0d high cycles want 0", it, bad); end
      rd(P_STAT, d);
      n_tests++; if (d !== {4'b0, pend}) begin n_fail++; $display("FAIL rand_left it%0d: got %h want %h", it, d, {4'b0, pend}); end
      for (int i = 0; i < NSRC; i++) if (pend[i]) io_wr(P_ACK, 8'(i));
      step();
    end
    io_wr(P_MASK, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_boundaries();
    test_reset_mid();
    test_random(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
